// File: rtl/wave_pkg.sv
// Shared state encoding and helpers for the multi-channel waveform scope.
package wave_pkg;
    localparam int COLOR_W = 6;
    localparam int MAX_CH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_HOLD
    } state_t;

    function automatic logic [31:0] clamp_u(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/wave_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module wave_capture_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/wave_scope_multi.sv
// Triggered multi-channel capture into circular buffers, then a frozen frame
// rendered as connected traces through a fixed 3-clock pixel pipeline.
module wave_scope_multi
    import wave_pkg::*;
#(
    parameter int X_OFF    = 0,
    parameter int Y_OFF    = 0,
    parameter int W        = 256,
    parameter int H        = 128,
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int PRE      = 64,
    parameter int TRIG_CH  = 0,
    parameter logic [COLOR_W*MAX_CH-1:0] COLORS = {6'b110000, 6'b001100, 6'b000011, 6'b111111}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic                       arm,
    input  logic [SAMPLE_W-1:0]        trig_level,
    input  logic                       trig_rising,
    output logic                       busy,
    output logic                       done,
    input  logic [9:0]                 x_px,
    input  logic [9:0]                 y_px,
    output logic [5:0]                 color_px,
    output state_t                     dbg_state
);
    localparam int AW     = $clog2(W);
    localparam int POST_N = W - PRE - 1;

    state_t              state;
    logic [AW-1:0]       wr_ptr, fill_cnt, post_cnt, start_addr;
    logic [SAMPLE_W-1:0] hist, trig_cur;
    logic                hist_valid, capturing, wr_en, trig_hit;

    assign trig_cur  = sample_in[SAMPLE_W*TRIG_CH +: SAMPLE_W];
    assign capturing = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
    assign wr_en     = capturing && sample_valid && !arm;
    assign trig_hit  = hist_valid && (trig_rising ?
                       (hist < trig_level && trig_cur >= trig_level) :
                       (hist > trig_level && trig_cur <= trig_level));
    assign dbg_state = state;

    // arm has priority over everything, including a same-cycle trigger; its sample is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            start_addr <= '0;
            hist       <= '0;
            hist_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (arm) begin
            state      <= (PRE == 0) ? ST_ARMED : ST_FILL;
            fill_cnt   <= '0;
            hist_valid <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else if (wr_en) begin
            wr_ptr     <= wr_ptr + AW'(1);
            hist       <= trig_cur;
            hist_valid <= 1'b1;
            case (state)
                ST_FILL: begin
                    fill_cnt <= fill_cnt + AW'(1);
                    if (fill_cnt == AW'(PRE - 1)) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        // Frame start is the trigger address minus the pre-trigger depth.
                        start_addr <= wr_ptr - AW'(PRE);
                        post_cnt   <= '0;
                        if (POST_N == 0) begin
                            state <= ST_HOLD;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    post_cnt <= post_cnt + AW'(1);
                    if (post_cnt == AW'(POST_N - 1)) begin
                        state <= ST_HOLD;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [31:0]   xe, ye;
    logic          in_win;
    logic [AW-1:0] col_c, rd_addr;
    logic [9:0]    s1_row, s2_row;
    logic          s1_win, s2_win, s1_first, s2_first;
    logic [NUM_CH-1:0] lit;
    logic [5:0]    color_nx;

    assign xe     = 32'(x_px);
    assign ye     = 32'(y_px);
    assign in_win = (xe >= 32'(X_OFF + 1)) && (xe <= 32'(X_OFF + W)) &&
                    (ye >= 32'(Y_OFF + 1)) && (ye <= 32'(Y_OFF + H));
    assign col_c  = AW'(xe - 32'(X_OFF) - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            s1_row   <= '0;
            s1_win   <= 1'b0;
            s1_first <= 1'b0;
            s2_row   <= '0;
            s2_win   <= 1'b0;
            s2_first <= 1'b0;
            color_px <= '0;
        end else begin
            rd_addr  <= start_addr + col_c;
            s1_row   <= 10'(ye - 32'(Y_OFF) - 32'd1);
            s1_win   <= in_win;
            s1_first <= (col_c == '0);
            s2_row   <= s1_row;
            s2_win   <= s1_win;
            s2_first <= s1_first;
            color_px <= (done && s2_win) ? color_nx : 6'd0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SAMPLE_W-1:0] rd_data, prv_q;
        logic [31:0]         cur, prv, lo, hi;

        wave_capture_ram #(.DEPTH(W), .DW(SAMPLE_W)) u_ram (
            .clk   (clk),
            .we    (wr_en),
            .waddr (wr_ptr),
            .wdata (sample_in[SAMPLE_W*i +: SAMPLE_W]),
            .raddr (rd_addr),
            .rdata (rd_data)
        );

        // prv_q holds the previous column's read because x advances one pixel per clock.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) prv_q <= '0;
            else        prv_q <= rd_data;
        end

        assign cur    = clamp_u(32'(rd_data), 32'(H - 1));
        assign prv    = s2_first ? cur : clamp_u(32'(prv_q), 32'(H - 1));
        assign lo     = (prv < cur) ? prv : cur;
        assign hi     = (prv < cur) ? cur : prv;
        assign lit[i] = (32'(s2_row) >= lo) && (32'(s2_row) <= hi);
    end

    always_comb begin
        color_nx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (lit[i]) color_nx = COLORS[COLOR_W*i +: COLOR_W];
    end
endmodule

// File: tb/tb_wave_scope_multi.sv
// Randomized bench for wave_scope_multi: three instances (main, PRE=0, PRE=W-1)
// share stimulus and are checked against a sample-history reference model.
module tb_wave_scope_multi;
    import wave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, sample_valid, arm, trig_rising;
    logic [15:0] sample_in;
    logic [7:0]  trig_level;
    logic [9:0]  x_px, y_px;
    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [5:0]  col0, col1, col2;
    state_t      st0, st1, st2;

    always #5 clk = ~clk;

    wave_scope_multi #(.X_OFF(5), .Y_OFF(3), .W(256), .H(128), .NUM_CH(2),
                       .SAMPLE_W(8), .PRE(64), .TRIG_CH(0)) u_main (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
        .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising),
        .busy(busy0), .done(done0), .x_px(x_px), .y_px(y_px),
        .color_px(col0), .dbg_state(st0));

    wave_scope_multi #(.W(16), .H(64), .NUM_CH(1), .SAMPLE_W(8), .PRE(0)) u_pre0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in[7:0]),
        .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising),
        .busy(busy1), .done(done1), .x_px(x_px), .y_px(y_px),
        .color_px(col1), .dbg_state(st1));

    wave_scope_multi #(.W(16), .H(64), .NUM_CH(1), .SAMPLE_W(8), .PRE(15)) u_pref (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in[7:0]),
        .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising),
        .busy(busy2), .done(done2), .x_px(x_px), .y_px(y_px),
        .color_px(col2), .dbg_state(st2));

    localparam int NK = 3;
    int k_w[NK]   = '{256, 16, 16};
    int k_pre[NK] = '{64, 0, 15};
    int k_h[NK]   = '{128, 64, 64};
    int k_x[NK]   = '{5, 0, 0};
    int k_y[NK]   = '{3, 0, 0};
    int k_nc[NK]  = '{2, 1, 1};
    logic [5:0] ch_color[2] = '{6'b111111, 6'b000011};

    // Model: samples since the last arm, per-instance phase (0 idle, 1 capturing, 2 frame held).
    int h0[$], h1[$];
    int m_st[NK], m_trig[NK];

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [5:0]  stat_q[$];
    int          stat_due[$];
    logic [17:0] pix_q[$];
    int          pix_due[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit crosses(int p, int c);
        if (trig_rising) return (p < int'(trig_level)) && (c >= int'(trig_level));
        return (p > int'(trig_level)) && (c <= int'(trig_level));
    endfunction

    task automatic model_step(input logic a, input logic v, input int s0, input int s1);
        int i;
        if (a) begin
            h0.delete();
            h1.delete();
            for (int k = 0; k < NK; k++) begin
                m_st[k]   = 1;
                m_trig[k] = -1;
            end
        end else if (v) begin
            h0.push_back(s0);
            h1.push_back(s1);
            i = h0.size() - 1;
            for (int k = 0; k < NK; k++) begin
                if (m_st[k] == 1) begin
                    if (m_trig[k] < 0 && i >= k_pre[k] && i >= 1 && crosses(h0[i-1], h0[i]))
                        m_trig[k] = i;
                    if (m_trig[k] >= 0 && i == m_trig[k] + k_w[k] - k_pre[k] - 1)
                        m_st[k] = 2;
                end
            end
        end
    endtask

    function automatic int fval(int k, int ch, int c);
        int idx;
        idx = m_trig[k] - k_pre[k] + c;
        return (ch == 0) ? h0[idx] : h1[idx];
    endfunction

    function automatic int clampi(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [5:0] exp_pix(int k, int x, int y);
        int c, r, cur, prv;
        if (m_st[k] != 2) return 6'd0;
        if (x < k_x[k] + 1 || x > k_x[k] + k_w[k] || y < k_y[k] + 1 || y > k_y[k] + k_h[k])
            return 6'd0;
        c = x - k_x[k] - 1;
        r = y - k_y[k] - 1;
        for (int ch = 0; ch < k_nc[k]; ch++) begin
            cur = clampi(fval(k, ch, c), k_h[k] - 1);
            prv = (c == 0) ? cur : clampi(fval(k, ch, c - 1), k_h[k] - 1);
            if ((r >= cur && r <= prv) || (r >= prv && r <= cur)) return ch_color[ch];
        end
        return 6'd0;
    endfunction

    function automatic bit all_done();
        for (int k = 0; k < NK; k++) if (m_st[k] != 2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input logic a, input logic v, input int s0, input int s1,
                         input int x, input int y, input bit chk_pix);
        @(posedge clk);
        #1;
        arm          = a;
        sample_valid = v;
        sample_in    = {8'(s1), 8'(s0)};
        x_px         = 10'(x);
        y_px         = 10'(y);
        model_step(a, v, s0, s1);
        stat_q.push_back({m_st[2] == 1, m_st[2] == 2, m_st[1] == 1, m_st[1] == 2,
                          m_st[0] == 1, m_st[0] == 2});
        stat_due.push_back(cyc + 1);
        if (chk_pix) begin
            pix_q.push_back({exp_pix(2, x, y), exp_pix(1, x, y), exp_pix(0, x, y)});
            pix_due.push_back(cyc + 3);
        end
    endtask

    always @(posedge clk) begin
        #2;
        while (stat_due.size() > 0 && stat_due[0] <= cyc) begin
            check("busy_done", {26'd0, busy2, done2, busy1, done1, busy0, done0}, {26'd0, stat_q[0]});
            void'(stat_q.pop_front());
            void'(stat_due.pop_front());
        end
        while (pix_due.size() > 0 && pix_due[0] <= cyc) begin
            check("color_px", {14'd0, col2, col1, col0}, {14'd0, pix_q[0]});
            void'(pix_q.pop_front());
            void'(pix_due.pop_front());
        end
    end

    task automatic gen(input int mode, output int s0, output int s1);
        int idx;
        idx = h0.size();
        s1  = int'($urandom_range(255));
        case (mode)
            0: begin s0 = idx % 256; s1 = 255 - (idx % 256); end
            1: s0 = (idx < 80) ? 200 : ((((idx - 80) / 5) % 2 == 0) ? 0 : 200);
            2: begin
                if (idx == 0)       s0 = 10;
                else if (idx == 1)  s0 = 20;
                else if (idx == 2)  s0 = 255;
                else if (idx < 64)  s0 = int'($urandom_range(99));
                else if (idx == 64) s0 = 150;
                else                s0 = int'($urandom_range(255));
            end
            3: begin s0 = (idx == 64) ? 120 : 40; s1 = (idx < 128) ? 40 : 60; end
            default: s0 = int'($urandom_range(255));
        endcase
    endtask

    task automatic start_capture(input logic rising, input int level);
        trig_rising = rising;
        trig_level  = 8'(level);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic feed_n(input int mode, input int count);
        int s0, s1;
        for (int i = 0; i < count; i++) begin
            gen(mode, s0, s1);
            drive(1'b0, 1'b1, s0, s1, 0, 0, 1'b0);
        end
    endtask

    task automatic feed(input int mode, input int budget, input int vpct);
        int s0, s1, t;
        logic v;
        t = 0;
        while (!all_done() && t < budget) begin
            v = ($urandom_range(99) < vpct);
            gen(mode, s0, s1);
            drive(1'b0, v, s0, s1, 0, 0, 1'b0);
            t++;
        end
        check("capture_complete", {31'd0, all_done()}, 32'd1);
    endtask

    task automatic scan_line(input int y);
        for (int x = 0; x <= 262; x++) drive(1'b0, 1'b0, 0, 0, x, y, 1'b1);
    endtask

    initial begin
        int wait_cnt;
        rst_n = 1'b0; arm = 1'b0; sample_valid = 1'b0; sample_in = '0;
        trig_level = '0; trig_rising = 1'b1; x_px = '0; y_px = '0;
        for (int k = 0; k < NK; k++) begin m_st[k] = 0; m_trig[k] = -1; end

        // Activity during reset must not leak to the outputs.
        repeat (6) begin
            @(posedge clk);
            #1;
            arm          = 1'($urandom_range(1));
            sample_valid = 1'b1;
            sample_in    = 16'($urandom);
            x_px         = 10'($urandom_range(1, 200));
            y_px         = 10'($urandom_range(1, 100));
            #2;
            check("reset_out_main", {23'd0, busy0, done0, col0}, 32'd0);
            check("reset_out_pre0", {23'd0, busy1, done1, col1}, 32'd0);
            check("reset_out_pref", {23'd0, busy2, done2, col2}, 32'd0);
        end
        @(posedge clk); #1;
        arm = 1'b0; sample_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_main", 32'(st0), 32'(ST_IDLE));
        check("idle_pre0", 32'(st1), 32'(ST_IDLE));
        check("idle_pref", 32'(st2), 32'(ST_IDLE));

        // Ramp capture, one sample per clock, rising trigger at 100.
        start_capture(1'b1, 100);
        feed(0, 2000, 100);
        scan_line(3 + 1 + 100);
        scan_line(3 + 1 + 36);
        scan_line(int'($urandom_range(0, 135)));

        // Falling trigger on a square wave; an arm lands on the first edge sample.
        start_capture(1'b0, 50);
        feed_n(1, 80);
        drive(1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
        feed(1, 3000, 75);
        scan_line(3 + 1 + 0);
        scan_line(3 + 1 + 100);

        // Interpolated columns and clamping of a full-scale sample.
        start_capture(1'b1, 100);
        feed(2, 3000, 80);
        foreach (k_w[j]) begin end
        scan_line(3 + 1 + 9);
        scan_line(3 + 1 + 10);
        scan_line(3 + 1 + 15);
        scan_line(3 + 1 + 20);
        scan_line(3 + 1 + 127);

        // Two channels overlapping at 40, then channel 1 alone at 60.
        start_capture(1'b1, 100);
        feed(3, 3000, 80);
        scan_line(3 + 1 + 40);
        scan_line(3 + 1 + 60);
        scan_line(3 + 1 + 50);

        // Random captures with a scan taken while the main instance is still busy.
        for (int run = 0; run < 3; run++) begin
            start_capture(1'($urandom_range(1)), int'($urandom_range(30, 220)));
            if (run == 0) begin
                feed_n(4, 40);
                scan_line(int'($urandom_range(0, 135)));
            end
            feed(4, 6000, 70);
            scan_line(int'($urandom_range(0, 135)));
            scan_line(int'($urandom_range(0, 135)));
        end

        // Asynchronous reset in the middle of a capture.
        start_capture(1'b1, 100);
        feed_n(4, 30);
        repeat (4) drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_main", {23'd0, busy0, done0, col0}, 32'd0);
        check("async_rst_state", 32'(st0), 32'(ST_IDLE));

        wait_cnt = 0;
        while ((stat_q.size() > 0 || pix_q.size() > 0) && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("queues_drained", 32'(stat_q.size() + pix_q.size()), 32'd0);
        rst_n = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
